// File: rtl/mmio_timer.sv
// Memory-mapped prescaled down-counter timer responding on the f8 data bus.
// Four 16-bit registers (CTRL, RELOAD, COUNT, STATUS) and a level interrupt on expiry.
module mmio_timer #(
    parameter logic [15:0] BASE     = 16'hff00,
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dread_addr,
    output logic [15:0] dread_data,
    output logic        dread_hit,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    input  logic [1:0]  dwrite_en,
    output logic        interrupt
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_RELOAD = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // r_ctrl bit0 EN, bit1 AR, bit2 IE
    logic [2:0]    r_ctrl;
    logic [15:0]   r_reload;
    logic [15:0]   r_count;
    logic          r_exp;
    logic [PW-1:0] r_pre;

    logic          w_tick;
    logic          w_expire;
    logic          w_wr_hit;
    logic [1:0]    w_wr_sel;
    logic [15:0]   w_count_tick;
    logic [15:0]   w_count_nxt;
    logic [15:0]   w_reload_nxt;
    logic [2:0]    w_ctrl_nxt;
    logic          w_exp_nxt;
    logic [PW-1:0] w_pre_nxt;
    logic          w_unused_bits;

    assign w_tick   = r_ctrl[0] && (r_pre == PRE_LAST);
    assign w_expire = w_tick && (r_count == 16'd0);
    assign w_wr_hit = (dwrite_addr[15:3] == BASE[15:3]) && (dwrite_en != 2'b00);
    assign w_wr_sel = dwrite_addr[2:1];

    assign w_unused_bits = ^{dread_addr[0], dwrite_addr[0]};

    always_comb begin
        w_pre_nxt = '0;
        if (r_ctrl[0] && (r_pre != PRE_LAST)) begin
            w_pre_nxt = r_pre + PW'(1);
        end
    end

    // Tick update first, then bus byte lanes override whatever they cover.
    always_comb begin
        w_count_tick = r_count;
        if (w_tick) begin
            if (r_count != 16'd0) begin
                w_count_tick = r_count - 16'd1;
            end else if (r_ctrl[1]) begin
                w_count_tick = r_reload;
            end
        end
        w_count_nxt = w_count_tick;
        if (w_wr_hit && (w_wr_sel == SEL_COUNT)) begin
            if (dwrite_en[0]) w_count_nxt[7:0]  = dwrite_data[7:0];
            if (dwrite_en[1]) w_count_nxt[15:8] = dwrite_data[15:8];
        end
    end

    always_comb begin
        w_reload_nxt = r_reload;
        if (w_wr_hit && (w_wr_sel == SEL_RELOAD)) begin
            if (dwrite_en[0]) w_reload_nxt[7:0]  = dwrite_data[7:0];
            if (dwrite_en[1]) w_reload_nxt[15:8] = dwrite_data[15:8];
        end
    end

    // A one-shot expiry drops EN unless the bus rewrites CTRL in that same cycle.
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_expire && !r_ctrl[1]) begin
            w_ctrl_nxt[0] = 1'b0;
        end
        if (w_wr_hit && (w_wr_sel == SEL_CTRL) && dwrite_en[0]) begin
            w_ctrl_nxt = dwrite_data[2:0];
        end
    end

    always_comb begin
        w_exp_nxt = r_exp;
        if (w_wr_hit && (w_wr_sel == SEL_STATUS) && dwrite_en[0] && dwrite_data[0]) begin
            w_exp_nxt = 1'b0;
        end
        if (w_expire) begin
            w_exp_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_reload <= '0;
            r_count  <= '0;
            r_exp    <= 1'b0;
            r_pre    <= '0;
        end else begin
            r_ctrl   <= w_ctrl_nxt;
            r_reload <= w_reload_nxt;
            r_count  <= w_count_nxt;
            r_exp    <= w_exp_nxt;
            r_pre    <= w_pre_nxt;
        end
    end

    assign dread_hit = (dread_addr[15:3] == BASE[15:3]);

    always_comb begin
        dread_data = 16'h0000;
        if (dread_hit) begin
            case (dread_addr[2:1])
                SEL_CTRL:   dread_data = {13'd0, r_ctrl};
                SEL_RELOAD: dread_data = r_reload;
                SEL_COUNT:  dread_data = r_count;
                SEL_STATUS: dread_data = {15'd0, r_exp};
                default:    dread_data = 16'h0000;
            endcase
        end
    end

    assign interrupt = r_exp & r_ctrl[2];

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed register/collision steps plus randomized
// timer programs checked against a closed-form arithmetic model of the count.
module tb_mmio_timer;

    localparam int          P      = 4;
    localparam logic [15:0] A_CTRL = 16'hff00;
    localparam logic [15:0] A_REL  = 16'hff02;
    localparam logic [15:0] A_CNT  = 16'hff04;
    localparam logic [15:0] A_STAT = 16'hff06;

    logic        clk;
    logic        reset;
    logic [15:0] dread_addr;
    logic [15:0] dread_data;
    logic        dread_hit;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic [1:0]  dwrite_en;
    logic        interrupt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    mmio_timer #(.BASE(16'hff00), .PRESCALE(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .dread_addr  (dread_addr),
        .dread_data  (dread_data),
        .dread_hit   (dread_hit),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_en   (dwrite_en),
        .interrupt   (interrupt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    // drivers: a write lands on the next posedge
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] en);
        dwrite_addr = a;
        dwrite_data = d;
        dwrite_en   = en;
        cycles(1);
        dwrite_en   = 2'b00;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic h);
        dread_addr = a;
        #1;
        d = dread_data;
        h = dread_hit;
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [15:0] a, input logic [15:0] expv);
        logic [15:0] d;
        logic        h;
        bus_read(a, d, h);
        check(tag, d, expv);
    endtask

    task automatic chk_irq(input string tag, input logic expv);
        check(tag, {15'd0, interrupt}, {15'd0, expv});
    endtask

    // reference model: k = ticks elapsed since the CTRL write
    function automatic logic [15:0] m_count(input int c, input int r, input bit ar, input int k);
        if (k <= c) return 16'(c - k);
        if (!ar) return 16'd0;
        return 16'(r - ((k - c - 1) % (r + 1)));
    endfunction

    initial begin
        logic [15:0] d;
        logic        h;
        int          c, r, k, tmax;
        bit          ar, ie, ex, en;

        reset       = 1'b1;
        dread_addr  = 16'h0000;
        dwrite_addr = 16'h0000;
        dwrite_data = 16'h0000;
        dwrite_en   = 2'b00;
        @(posedge clk);
        #1;
        cycles(1);
        reset = 1'b0;

        // reset state and decode
        for (int i = 0; i < 4; i++) begin
            bus_read(A_CTRL + 16'(2 * i), d, h);
            check($sformatf("reset_reg%0d", i), d, 16'h0000);
            check($sformatf("reset_hit%0d", i), {15'd0, h}, 16'd1);
        end
        chk_irq("reset_irq", 1'b0);
        bus_read(16'hff08, d, h);
        check("miss_hi_hit", {15'd0, h}, 16'd0);
        check("miss_hi_data", d, 16'h0000);
        bus_read(16'hfefe, d, h);
        check("miss_lo_hit", {15'd0, h}, 16'd0);

        // one-shot: expiry at N + (3+1)*4
        bus_write(A_CNT, 16'd3, 2'b11);
        bus_write(A_CTRL, 16'h0005, 2'b01);
        cycles(15);
        chk_irq("oneshot_irq_early", 1'b0);
        chk_reg("oneshot_stat_early", A_STAT, 16'h0000);
        cycles(1);
        chk_irq("oneshot_irq", 1'b1);
        chk_reg("oneshot_ctrl", A_CTRL, 16'h0004);
        chk_reg("oneshot_ctrl_odd", 16'hff01, 16'h0004);
        chk_reg("oneshot_count", A_CNT, 16'h0000);
        chk_reg("oneshot_stat", A_STAT, 16'h0001);
        bus_write(A_STAT, 16'h0001, 2'b01);
        chk_irq("oneshot_irq_clr", 1'b0);
        chk_reg("oneshot_stat_clr", A_STAT, 16'h0000);
        cycles(20);
        chk_reg("oneshot_stays_idle", A_STAT, 16'h0000);

        // auto-reload: expiries at N+12 and N+24, clear EXP at N+13
        do_reset();
        bus_write(A_REL, 16'd2, 2'b11);
        bus_write(A_CNT, 16'd2, 2'b11);
        bus_write(A_CTRL, 16'h0007, 2'b01);
        for (int i = 0; i < 7; i++) exp_q.push_back(16'(2 - (i % 3)));
        chk_reg("ar_count_t0", A_CNT, exp_q.pop_front());
        for (int t = 1; t <= 24; t++) begin
            if (t == 13) bus_write(A_STAT, 16'h0001, 2'b01);
            else cycles(1);
            if (t % 4 == 0) chk_reg($sformatf("ar_count_t%0d", t), A_CNT, exp_q.pop_front());
            chk_reg($sformatf("ar_stat_t%0d", t), A_STAT, (t == 12 || t >= 24) ? 16'd1 : 16'd0);
        end
        chk_reg("ar_ctrl", A_CTRL, 16'h0007);
        chk_irq("ar_irq", 1'b1);

        // byte lanes and CTRL reserved bits
        bus_write(A_REL, 16'hABCD, 2'b01);
        bus_write(A_REL, 16'h1234, 2'b10);
        chk_reg("lanes_reload", A_REL, 16'h12CD);
        bus_write(A_REL, 16'hFFFF, 2'b00);
        chk_reg("lanes_no_en", A_REL, 16'h12CD);
        do_reset();
        bus_write(A_CTRL, 16'hFFF8, 2'b11);
        chk_reg("ctrl_reserved", A_CTRL, 16'h0000);

        // collision: STATUS clear on the expiry edge
        do_reset();
        bus_write(A_CNT, 16'd0, 2'b11);
        bus_write(A_CTRL, 16'h0005, 2'b01);
        cycles(3);
        bus_write(A_STAT, 16'h0001, 2'b01);
        chk_reg("col_clr_stat", A_STAT, 16'h0001);
        chk_irq("col_clr_irq", 1'b1);
        chk_reg("col_clr_ctrl", A_CTRL, 16'h0004);
        bus_write(A_STAT, 16'h0000, 2'b11);
        chk_reg("stat_write0", A_STAT, 16'h0001);
        bus_write(A_STAT, 16'h0001, 2'b10);
        chk_reg("stat_hi_lane", A_STAT, 16'h0001);

        // collision: CTRL write on one-shot expiry edge keeps written EN
        do_reset();
        bus_write(A_CNT, 16'd0, 2'b11);
        bus_write(A_CTRL, 16'h0001, 2'b01);
        cycles(3);
        bus_write(A_CTRL, 16'h0005, 2'b01);
        chk_reg("col_ctrl_ctrl", A_CTRL, 16'h0005);
        chk_reg("col_ctrl_stat", A_STAT, 16'h0001);

        // collision: RELOAD write on expiry edge loads the old RELOAD
        do_reset();
        bus_write(A_REL, 16'd3, 2'b11);
        bus_write(A_CNT, 16'd0, 2'b11);
        bus_write(A_CTRL, 16'h0003, 2'b01);
        cycles(3);
        bus_write(A_REL, 16'd9, 2'b11);
        chk_reg("col_rel_count", A_CNT, 16'd3);
        chk_reg("col_rel_reload", A_REL, 16'd9);

        // collision: COUNT write on tick edges (ticks at N+4, N+8)
        do_reset();
        bus_write(A_CNT, 16'd9, 2'b11);
        bus_write(A_CTRL, 16'h0001, 2'b01);
        cycles(3);
        bus_write(A_CNT, 16'h0010, 2'b11);
        chk_reg("col_cnt_full", A_CNT, 16'h0010);
        bus_write(A_CNT, 16'h0100, 2'b11);
        cycles(2);
        bus_write(A_CNT, 16'hEE33, 2'b01);
        chk_reg("col_cnt_lane", A_CNT, 16'h0033);

        // reset mid-run with COUNT=5, EN=1, EXP=1; write during reset ignored
        do_reset();
        bus_write(A_REL, 16'd5, 2'b11);
        bus_write(A_CNT, 16'd0, 2'b11);
        bus_write(A_CTRL, 16'h0007, 2'b01);
        cycles(3);
        chk_reg("mid_pre_count", A_CNT, 16'd0);
        cycles(1);
        chk_reg("mid_count", A_CNT, 16'd5);
        chk_irq("mid_irq", 1'b1);
        reset = 1'b1;
        bus_write(A_CNT, 16'd7, 2'b11);
        chk_reg("mid_rst_count", A_CNT, 16'd0);
        chk_reg("mid_rst_ctrl", A_CTRL, 16'd0);
        chk_reg("mid_rst_reload", A_REL, 16'd0);
        chk_reg("mid_rst_stat", A_STAT, 16'd0);
        chk_irq("mid_rst_irq", 1'b0);
        reset = 1'b0;
        cycles(40);
        chk_reg("post_rst_count", A_CNT, 16'd0);
        chk_reg("post_rst_stat", A_STAT, 16'd0);
        chk_irq("post_rst_irq", 1'b0);

        // randomized programs against the arithmetic model
        for (int n = 0; n < 8; n++) begin
            do_reset();
            c  = $urandom_range(0, 5);
            r  = $urandom_range(0, 5);
            ar = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            bus_write(A_REL, 16'(r), 2'b11);
            bus_write(A_CNT, 16'(c), 2'b11);
            bus_write(A_CTRL, {13'd0, ie, ar, 1'b1}, 2'b01);
            tmax = (c + 1) * P + 2 * (r + 1) * P + 2;
            for (int t = 1; t <= tmax; t++) begin
                cycles(1);
                k  = t / P;
                ex = (k >= c + 1);
                en = ar || (k < c + 1);
                chk_reg($sformatf("rnd%0d_count_t%0d", n, t), A_CNT, m_count(c, r, ar, k));
                chk_reg($sformatf("rnd%0d_stat_t%0d", n, t), A_STAT, {15'd0, ex});
                chk_reg($sformatf("rnd%0d_ctrl_t%0d", n, t), A_CTRL, {13'd0, ie, ar, en});
                chk_irq($sformatf("rnd%0d_irq_t%0d", n, t), ex & ie);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
